// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges pipeline and long-latency register writes onto one GRF write port
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic [31:0] m_pc,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_pend1,
  output logic        q_pend2
);
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_p_acc, w_enq, w_pop, w_pend1, w_pend2;
  assign w_p_acc = p_valid & (p_addr != 5'd0);
  assign m_ready = r_cnt != (AW+1)'(DEPTH);
  assign w_enq   = m_valid & m_ready & (m_addr != 5'd0);
  assign w_pop   = ~w_p_acc & (r_cnt != '0);
  // live is cleared on pop, so a live bit alone marks a valid, uncommitted entry
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend1 = w_pend1 | (r_live[i] & (r_addr[i] == q_a1));
      w_pend2 = w_pend2 | (r_live[i] & (r_addr[i] == q_a2));
    end
  end
  assign q_pend1 = w_pend1 & (q_a1 != 5'd0);
  assign q_pend2 = w_pend2 & (q_a2 != 5'd0);
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wp] <= m_addr;
      r_data[r_wp] <= m_data;
      r_pc[r_wp]   <= m_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_live <= '0;
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_p_acc && r_addr[i] == p_addr) r_live[i] <= 1'b0;
      if (w_pop) begin
        r_live[r_rp] <= 1'b0;
        r_rp         <= r_rp + 1'b1;
      end
      // a same-cycle pipeline write to the same register makes the new entry stale on arrival
      if (w_enq) begin
        r_live[r_wp] <= ~(w_p_acc && m_addr == p_addr);
        r_wp         <= r_wp + 1'b1;
      end
      r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_pop);
      if (w_p_acc) begin
        grf_we <= 1'b1;
        grf_a3 <= p_addr;
        grf_wd <= p_data;
        grf_pc <= p_pc;
      end else if (w_pop) begin
        grf_we <= r_live[r_rp];
        if (r_live[r_rp]) begin
          grf_a3 <= r_addr[r_rp];
          grf_wd <= r_data[r_rp];
          grf_pc <= r_pc[r_rp];
        end
      end else begin
        grf_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed scenarios plus random traffic against a queue-based write-port model
module tb_grf_wb_arbiter;
  logic        clk, reset, p_valid, m_valid, m_ready, grf_we, q_pend1, q_pend2;
  logic [4:0]  p_addr, m_addr, grf_a3, q_a1, q_a2;
  logic [31:0] p_data, p_pc, m_data, m_pc, grf_wd, grf_pc;
  int n_vec = 0, n_err = 0;
  typedef struct packed {logic [4:0] a; logic [31:0] d; logic [31:0] p; logic live;} ent_t;
  ent_t mq[$];
  logic        exp_we = 0;
  logic [4:0]  exp_a3 = 0;
  logic [31:0] exp_wd = 0, exp_pc = 0;

  grf_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .q_a1(q_a1), .q_a2(q_a2), .q_pend1(q_pend1), .q_pend2(q_pend2));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic mpend(input logic [4:0] a);
    if (a == 0) return 0;
    foreach (mq[i]) if (mq[i].live && mq[i].a == a) return 1;
    return 0;
  endfunction

  function automatic logic mready();
    return mq.size() != 4;
  endfunction

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd, pp,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md, mp);
    p_valid = pv; p_addr = pa; p_data = pd; p_pc = pp;
    m_valid = mv; m_addr = ma; m_data = md; m_pc = mp;
    #1;
  endtask

  // advance one clock, updating the model from the inputs presented at this edge
  task automatic tick();
    logic mr, acc;
    ent_t h;
    mr = mready();
    acc = p_valid && p_addr != 0;
    if (reset) begin
      mq.delete();
      exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_pc = 0;
    end else begin
      if (acc) begin
        foreach (mq[i]) if (mq[i].a == p_addr) mq[i].live = 0;
        exp_we = 1; exp_a3 = p_addr; exp_wd = p_data; exp_pc = p_pc;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        exp_we = h.live;
        if (h.live) begin exp_a3 = h.a; exp_wd = h.d; exp_pc = h.p; end
      end else exp_we = 0;
      if (m_valid && mr && m_addr != 0) mq.push_back({m_addr, m_data, m_pc, !(acc && m_addr == p_addr)});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    q_a1 = 8; q_a2 = 9;
    tick(); tick();
    reset = 0; #1;
    n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b want 0", grf_we); end
    n_vec++; if (grf_a3 !== 5'd0 || grf_wd !== 32'd0 || grf_pc !== 32'd0) begin n_err++; $display("FAIL reset_fields got %0h/%0h/%0h want 0/0/0", grf_a3, grf_wd, grf_pc); end
    n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_mready got %0b want 1", m_ready); end
    n_vec++; if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_err++; $display("FAIL reset_pend got %0b%0b want 00", q_pend1, q_pend2); end
  endtask

  task automatic test_pipe_write();
    drive(1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0);
    tick();
    n_vec++; if (grf_we !== 1'b1 || grf_a3 !== 5'd5) begin n_err++; $display("FAIL pipe_we_a3 got %0b/%0d want 1/5", grf_we, grf_a3); end
    n_vec++; if (grf_wd !== 32'h1234 || grf_pc !== 32'h3000) begin n_err++; $display("FAIL pipe_wd_pc got %0h/%0h want 1234/3000", grf_wd, grf_pc); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (grf_we !== 1'b0 || grf_a3 !== 5'd5 || grf_wd !== 32'h1234) begin n_err++; $display("FAIL idle_hold got %0b/%0d/%0h want 0/5/1234", grf_we, grf_a3, grf_wd); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h100 + i, 32'h2000, 1, 5'(8 + i), 32'hC000 + i, 32'h5000 + 4 * i);
      n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d got %0b want 1", i, m_ready); end
      tick();
    end
    drive(1, 1, 32'h200, 32'h2010, 0, 0, 0, 0);
    q_a1 = 8; q_a2 = 11; #1;
    n_vec++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b want 0", m_ready); end
    n_vec++; if (q_pend1 !== 1'b1 || q_pend2 !== 1'b1) begin n_err++; $display("FAIL full_pend got %0b%0b want 11", q_pend1, q_pend2); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (grf_we !== 1'b1 || grf_a3 !== 5'(8 + i) || grf_wd !== 32'hC000 + i || grf_pc !== 32'h5000 + 4 * i)
        begin n_err++; $display("FAIL drain%0d got %0b/%0d/%0h/%0h want 1/%0d/%0h/%0h", i, grf_we, grf_a3, grf_wd, grf_pc, 8 + i, 32'hC000 + i, 32'h5000 + 4 * i); end
      if (i == 0) begin
        n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready got %0b want 1", m_ready); end
      end
    end
  endtask

  task automatic test_stale();
    drive(0, 0, 0, 0, 1, 7, 32'hAAAA, 32'h4000);
    tick();
    drive(1, 7, 32'hBBBB, 32'h4004, 0, 0, 0, 0);
    q_a1 = 7; #1;
    n_vec++; if (q_pend1 !== 1'b1) begin n_err++; $display("FAIL stale_pend_before got %0b want 1", q_pend1); end
    tick();
    n_vec++; if (q_pend1 !== 1'b0) begin n_err++; $display("FAIL stale_pend_after got %0b want 0", q_pend1); end
    n_vec++; if (grf_we !== 1'b1 || grf_a3 !== 5'd7 || grf_wd !== 32'hBBBB) begin n_err++; $display("FAIL stale_pwrite got %0b/%0d/%0h want 1/7/bbbb", grf_we, grf_a3, grf_wd); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL stale_dead_pop got %0b want 0", grf_we); end
    tick();
    n_vec++; if (grf_we !== 1'b0 || m_ready !== 1'b1) begin n_err++; $display("FAIL stale_empty got %0b/%0b want 0/1", grf_we, m_ready); end
  endtask

  task automatic test_zero_addr();
    drive(0, 0, 0, 0, 1, 0, 32'h5555, 32'h6000);
    n_vec++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got %0b want 1", m_ready); end
    tick();
    n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL zero_m_we got %0b want 0", grf_we); end
    drive(1, 0, 32'h7777, 32'h6004, 0, 0, 0, 0);
    tick();
    n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL zero_p_we got %0b want 0", grf_we); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL zero_no_pop got %0b want 0", grf_we); end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 32'h300 + i, 32'h7000, 1, 5'(12 + i), 32'hD000 + i, 32'h7100);
      tick();
    end
    q_a1 = 12; q_a2 = 14;
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0; #1;
    n_vec++; if (grf_we !== 1'b0 || grf_a3 !== 5'd0 || m_ready !== 1'b1) begin n_err++; $display("FAIL flush_state got %0b/%0d/%0b want 0/0/1", grf_we, grf_a3, m_ready); end
    n_vec++; if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin n_err++; $display("FAIL flush_pend got %0b%0b want 00", q_pend1, q_pend2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (grf_we !== 1'b0) begin n_err++; $display("FAIL flush_nowrite%0d got %0b want 0", i, grf_we); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      q_a1 = 5'($urandom_range(0, 7)); q_a2 = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom, $urandom);
      n_vec++; if (m_ready !== mready()) begin n_err++; $display("FAIL rnd_ready@%0d got %0b want %0b", n, m_ready, mready()); end
      n_vec++; if (q_pend1 !== mpend(q_a1)) begin n_err++; $display("FAIL rnd_pend1@%0d a=%0d got %0b want %0b", n, q_a1, q_pend1, mpend(q_a1)); end
      n_vec++; if (q_pend2 !== mpend(q_a2)) begin n_err++; $display("FAIL rnd_pend2@%0d a=%0d got %0b want %0b", n, q_a2, q_pend2, mpend(q_a2)); end
      tick();
      n_vec++; if (grf_we !== exp_we) begin n_err++; $display("FAIL rnd_we@%0d got %0b want %0b", n, grf_we, exp_we); end
      if (exp_we) begin
        n_vec++; if (grf_a3 !== exp_a3 || grf_wd !== exp_wd || grf_pc !== exp_pc)
          begin n_err++; $display("FAIL rnd_write@%0d got %0d/%0h/%0h want %0d/%0h/%0h", n, grf_a3, grf_wd, grf_pc, exp_a3, exp_wd, exp_pc); end
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; q_a1 = 0; q_a2 = 0;
    test_reset();
    test_pipe_write();
    test_fill_drain();
    test_stale();
    test_zero_addr();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
